// File: rtl/awg_key_ctrl_pkg.sv
// Shared codes for the AWG front panel: waveform codes (same as the waveform
// generator), parameter-select codes, key indices and the FSM step helpers.
package awg_key_ctrl_pkg;

  localparam logic [4:0] WAVE_SAW  = 5'd0;
  localparam logic [4:0] WAVE_TRI  = 5'd1;
  localparam logic [4:0] WAVE_SQR  = 5'd2;
  localparam logic [4:0] WAVE_SIN  = 5'd3;
  localparam logic [4:0] WAVE_RAND = 5'd4;
  localparam logic [4:0] WAVE_OFF  = 5'd10;

  typedef enum logic [1:0] {
    SEL_FREQ  = 2'd0,
    SEL_AMP   = 2'd1,
    SEL_PHASE = 2'd2
  } sel_e;

  localparam int NUM_KEYS = 4;
  localparam int KEY_MODE = 0;
  localparam int KEY_SEL  = 1;
  localparam int KEY_UP   = 2;
  localparam int KEY_DOWN = 3;

  // Unreachable codes fall back to saw.
  function automatic logic [4:0] next_wave(input logic [4:0] w);
    case (w)
      WAVE_SAW:  return WAVE_TRI;
      WAVE_TRI:  return WAVE_SQR;
      WAVE_SQR:  return WAVE_SIN;
      WAVE_SIN:  return WAVE_RAND;
      WAVE_RAND: return WAVE_OFF;
      default:   return WAVE_SAW;
    endcase
  endfunction

  function automatic sel_e next_sel(input sel_e s);
    case (s)
      SEL_FREQ: return SEL_AMP;
      SEL_AMP:  return SEL_PHASE;
      default:  return SEL_FREQ;
    endcase
  endfunction

  function automatic logic [7:0] step_sat(input logic [7:0] v, input logic up, input logic dn,
                                          input logic [7:0] lo, input logic [7:0] hi);
    if (up && v < hi) return v + 8'd1;
    if (dn && v > lo) return v - 8'd1;
    return v;
  endfunction

endpackage

// File: rtl/awg_key_ctrl_key_debounce.sv
// One push-button: 2-flop sync, level debounce, 1-cycle press pulse and
// optional hold-to-repeat pulses while the debounced level stays pressed.
module key_debounce #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned RPT_CYCLES  = 5_000_000,
  parameter bit          RPT_EN      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CMAX0 = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
  localparam int unsigned CMAX  = (CMAX0 > RPT_CYCLES) ? CMAX0 : RPT_CYCLES;
  localparam int          CW    = $clog2(CMAX + 1);

  logic [1:0]    sync;
  logic          db_n;
  logic [CW-1:0] db_cnt, rpt_cnt;
  logic          rpt_phase;
  logic          mismatch, flip;

  assign mismatch = sync[1] != db_n;
  assign flip     = mismatch && (db_cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      db_n      <= 1'b1;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (flip) begin
        db_n      <= sync[1];
        db_cnt    <= '0;
        press     <= ~sync[1];
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else begin
        db_cnt <= mismatch ? db_cnt + 1'b1 : '0;
        // First repeat waits HOLD_CYCLES from the press, later ones RPT_CYCLES.
        if (RPT_EN && !db_n) begin
          if (rpt_cnt == (rpt_phase ? CW'(RPT_CYCLES - 1) : CW'(HOLD_CYCLES - 1))) begin
            press     <= 1'b1;
            rpt_cnt   <= '0;
            rpt_phase <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/awg_key_ctrl.sv
// Front-panel controller: four debounced keys drive the waveform select,
// the parameter select and saturating freq/amp/phase steps for the AWG.
module awg_key_ctrl
  import awg_key_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned RPT_CYCLES  = 5_000_000,
  parameter logic [7:0]  FREQ_DEF    = 8'd10,
  parameter logic [7:0]  FREQ_MIN    = 8'd1,
  parameter logic [7:0]  FREQ_MAX    = 8'd200,
  parameter logic [7:0]  AMP_MAX     = 8'd9,
  parameter logic [7:0]  PHASE_MAX   = 8'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_sel_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  output logic [4:0] state,
  output logic [7:0] state_freq,
  output logic [7:0] state_amp,
  output logic [7:0] state_phase,
  output logic [1:0] param_sel,
  output logic       upd
);

  logic [NUM_KEYS-1:0] keys_n, press;

  assign keys_n = {key_down_n, key_up_n, key_sel_n, key_mode_n};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .RPT_CYCLES (RPT_CYCLES),
      .RPT_EN     (i == KEY_UP || i == KEY_DOWN)
    ) u_key (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(keys_n[i]),
      .press(press[i])
    );
  end

  logic [4:0] wave_d;
  logic [7:0] freq_d, amp_d, phase_d;
  sel_e       sel_q, sel_d;
  logic       adj_up, adj_dn;

  // Up/down act on the selection held before any simultaneous sel press.
  always_comb begin
    wave_d  = state;
    freq_d  = state_freq;
    amp_d   = state_amp;
    phase_d = state_phase;
    sel_d   = sel_q;
    adj_up  = press[KEY_UP] & ~press[KEY_DOWN];
    adj_dn  = press[KEY_DOWN] & ~press[KEY_UP];
    if (press[KEY_MODE]) wave_d = next_wave(state);
    if (press[KEY_SEL])  sel_d  = next_sel(sel_q);
    case (sel_q)
      SEL_FREQ:  freq_d  = step_sat(state_freq, adj_up, adj_dn, FREQ_MIN, FREQ_MAX);
      SEL_AMP:   amp_d   = step_sat(state_amp, adj_up, adj_dn, 8'd0, AMP_MAX);
      SEL_PHASE: phase_d = step_sat(state_phase, adj_up, adj_dn, 8'd0, PHASE_MAX);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAVE_SAW;
      state_freq  <= FREQ_DEF;
      state_amp   <= 8'd0;
      state_phase <= 8'd0;
      sel_q       <= SEL_FREQ;
      upd         <= 1'b0;
    end else begin
      state       <= wave_d;
      state_freq  <= freq_d;
      state_amp   <= amp_d;
      state_phase <= phase_d;
      sel_q       <= sel_d;
      upd         <= (wave_d != state) || (freq_d != state_freq) ||
                     (amp_d != state_amp) || (phase_d != state_phase);
    end
  end

  assign param_sel = sel_q;

endmodule

// File: tb/tb_awg_key_ctrl.sv
// Bench for awg_key_ctrl: window-based key model, per-cycle output compare,
// and directed sequences with literal expectations.
module tb_awg_key_ctrl;

  localparam int DB = 4, HOLD = 20, RPT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keys = 4'hF;   // 0 mode, 1 sel, 2 up, 3 down
  logic [4:0] state;
  logic [7:0] state_freq, state_amp, state_phase;
  logic [1:0] param_sel;
  logic       upd;

  int n_tests = 0, n_fail = 0, upd_seen = 0;

  awg_key_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(keys[0]), .key_sel_n(keys[1]), .key_up_n(keys[2]), .key_down_n(keys[3]),
    .state(state), .state_freq(state_freq), .state_amp(state_amp),
    .state_phase(state_phase), .param_sel(param_sel), .upd(upd)
  );

  always #5 clk = ~clk;

  // ---- behavioural model ----
  int   m_wave, m_freq, m_amp, m_phase, m_sel;
  bit   m_upd;
  bit   hist[4][8];      // hist[k][j] = raw key level sampled j edges ago
  bit   dbm[4];          // debounced level, 1 = released
  int   pedge[4];
  bit   pend[4];         // pulse produced at this edge, takes effect next edge
  int   edge_n;
  int   wseq[6] = '{0, 1, 2, 3, 4, 10};

  task automatic model_reset();
    m_wave = 0; m_freq = 10; m_amp = 0; m_phase = 0; m_sel = 0; m_upd = 0;
    edge_n = 0;
    for (int k = 0; k < 4; k++) begin
      dbm[k] = 1; pend[k] = 0; pedge[k] = 0;
      for (int j = 0; j < 8; j++) hist[k][j] = 1;
    end
  endtask

  task automatic model_step();
    int ow, of, oa, op, idx, d;
    bit all_diff;
    ow = m_wave; of = m_freq; oa = m_amp; op = m_phase;
    if (pend[0]) begin
      idx = 0;
      for (int i = 0; i < 6; i++) if (wseq[i] == m_wave) idx = i;
      m_wave = wseq[(idx + 1) % 6];
    end
    if (pend[2] != pend[3]) begin
      d = pend[2] ? 1 : -1;
      case (m_sel)
        0: if (m_freq + d >= 1 && m_freq + d <= 200) m_freq += d;
        1: if (m_amp + d >= 0 && m_amp + d <= 9) m_amp += d;
        default: if (m_phase + d >= 0 && m_phase + d <= 9) m_phase += d;
      endcase
    end
    if (pend[1]) m_sel = (m_sel + 1) % 3;
    m_upd = (ow != m_wave) || (of != m_freq) || (oa != m_amp) || (op != m_phase);
    edge_n++;
    for (int k = 0; k < 4; k++) begin
      for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = keys[k];
      // The synchroniser shows the sample from two edges ago; accept after DB differing ones.
      all_diff = 1;
      for (int j = 2; j < DB + 2; j++) if (hist[k][j] == dbm[k]) all_diff = 0;
      pend[k] = 0;
      if (all_diff) begin
        dbm[k] = !dbm[k];
        if (!dbm[k]) begin pend[k] = 1; pedge[k] = edge_n; end
      end else if (k >= 2 && !dbm[k]) begin
        d = edge_n - pedge[k];
        if (d >= HOLD && (d - HOLD) % RPT == 0) pend[k] = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---- per-cycle compare ----
  initial begin
    forever begin
      @(negedge clk);
      n_tests++;
      if (upd) upd_seen++;
      if (state !== 5'(m_wave) || state_freq !== 8'(m_freq) || state_amp !== 8'(m_amp) ||
          state_phase !== 8'(m_phase) || param_sel !== 2'(m_sel) || upd !== m_upd) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got st=%0d f=%0d a=%0d p=%0d sel=%0d upd=%0b want st=%0d f=%0d a=%0d p=%0d sel=%0d upd=%0b",
                 $time, state, state_freq, state_amp, state_phase, param_sel, upd,
                 m_wave, m_freq, m_amp, m_phase, m_sel, m_upd);
      end
    end
  end

  // ---- directed helpers ----
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_state", state, 0);  chk("rst_freq", state_freq, 10);
    chk("rst_amp", state_amp, 0); chk("rst_phase", state_phase, 0);
    chk("rst_sel", param_sel, 0); chk("rst_upd", upd, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic press(input logic [3:0] mask, input int low, input int high);
    @(negedge clk);
    keys = ~mask;
    repeat (low) @(negedge clk);
    keys = 4'hF;
    repeat (high) @(negedge clk);
  endtask

  // ---- stimulus ----
  initial begin
    int exp_w[6] = '{1, 2, 3, 4, 10, 0};
    repeat (3) @(negedge clk);
    rst_n = 1;
    do_reset();

    // Glitch shorter than DB cycles: nothing.
    press(4'b0001, 3, 10);
    chk("glitch_state", state, 0);

    // Exact latency: low sampled at edge k, state changes at edge k+6.
    @(negedge clk);
    keys[0] = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("lat_state_%0d", i), state, (i >= 6) ? 1 : 0);
      chk($sformatf("lat_upd_%0d", i), upd, (i == 6) ? 1 : 0);
    end
    keys[0] = 1;
    repeat (10) @(negedge clk);

    // Mode wrap from reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press(4'b0001, 6, 10);
      chk($sformatf("wrap_%0d", i), state, exp_w[i]);
    end

    // Saturation on amp then freq.
    do_reset();
    press(4'b0010, 6, 10);
    chk("sel_amp", param_sel, 1);
    upd_seen = 0;
    for (int i = 0; i < 12; i++) press(4'b0100, 6, 10);
    chk("amp_max", state_amp, 9);
    chk("amp_upd_cnt", upd_seen, 9);
    for (int i = 0; i < 12; i++) press(4'b1000, 6, 10);
    chk("amp_min", state_amp, 0);
    press(4'b0010, 6, 10);
    press(4'b0010, 6, 10);
    chk("sel_freq", param_sel, 0);
    for (int i = 0; i < 9; i++) press(4'b1000, 6, 10);
    chk("freq_dn9", state_freq, 1);
    upd_seen = 0;
    press(4'b1000, 6, 10);
    chk("freq_min", state_freq, 1);
    chk("freq_min_upd", upd_seen, 0);

    // Hold-to-repeat on freq: 11 at press, then +20, +25, +30, +35 edges -> 15.
    do_reset();
    press(4'b0100, 40, 12);
    chk("repeat_freq", state_freq, 15);

    // up+down together ignored; sel+up together adjusts freq then moves sel.
    do_reset();
    press(4'b1100, 8, 10);
    chk("updn_freq", state_freq, 10);
    press(4'b0110, 8, 10);
    chk("selup_freq", state_freq, 11);
    chk("selup_sel", param_sel, 1);

    // Reset mid-debounce with the key held through reset release.
    do_reset();
    press(4'b0001, 6, 10);
    chk("pre_mid_state", state, 1);
    @(negedge clk);
    keys[0] = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("mid_rst_state", state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    keys[0] = 1;
    repeat (10) @(negedge clk);
    chk("held_thru_rst", state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
